// File: rtl/sha256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_pkg                                                           |
// | Shared SHA-256 constants, widths and nonce-scheduler state codes.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sha256_pkg;

    localparam int HASH_W    = 256;
    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERST = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    localparam logic [WORD_W-1:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [WORD_W-1:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // A target wider than the hash can only be met by an all-zero hash.
    function automatic logic [8:0] clamp_zbits(input logic [8:0] z);
        return (z > 9'd256) ? 9'd256 : z;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_nonce_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_nonce_sched_if                                                |
// | Scheduler <-> engine/FIFO signal bundle.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sha256_nonce_sched_if;
    import sha256_pkg::*;

    logic              eng_rstn_o;
    logic              eng_start_o;
    logic              eng_dbl_hash_o;
    logic              eng_valid_i;
    logic [HASH_W-1:0] eng_hash_i;
    logic              fifo_full_i;
    logic              fifo_wr_en_o;
    logic [WORD_W-1:0] fifo_wr_dat_o;

    modport master (
        output eng_rstn_o, eng_start_o, eng_dbl_hash_o, fifo_wr_en_o, fifo_wr_dat_o,
        input  eng_valid_i, eng_hash_i, fifo_full_i
    );

    modport slave (
        input  eng_rstn_o, eng_start_o, eng_dbl_hash_o, fifo_wr_en_o, fifo_wr_dat_o,
        output eng_valid_i, eng_hash_i, fifo_full_i
    );
endinterface
`default_nettype wire

// File: rtl/sha256_lzc256.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_lzc256                                                        |
// | Combinational leading-zero count of a 256-bit hash (0..256).         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha256_lzc256
    import sha256_pkg::*;
(
    input  logic [HASH_W-1:0] din,
    output logic [8:0]        lz
);
    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        lz = 9'd256;
        for (int i = 0; i < HASH_W; i++) begin
            if (din[i]) lz = 9'(HASH_W - 1 - i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/sha256_nonce_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_nonce_sched                                                   |
// | Sequences one SHA-256 engine through a nonce sweep to a zero target. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha256_nonce_sched
    import sha256_pkg::*;
#(
    parameter int RST_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 msg_we_i,
    input  logic [4:0]           msg_addr_i,
    input  logic [WORD_W-1:0]    msg_dat_i,
    input  logic                 blocks_i,
    input  logic [4:0]           nonce_idx_i,
    input  logic [WORD_W-1:0]    nonce_start_i,
    input  logic [WORD_W-1:0]    nonce_count_i,
    input  logic [8:0]           zbits_i,
    input  logic                 dbl_hash_i,
    input  logic                 go_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 found_o,
    output logic                 error_o,
    output logic [WORD_W-1:0]    found_nonce_o,
    output logic [HASH_W-1:0]    found_hash_o,
    output logic [WORD_W-1:0]    hashes_done_o,
    sha256_nonce_sched_if.master eng
);
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    if (RST_CYC < 1 || FIFO_DEPTH < 2 * BLK_WORDS) begin : g_param_chk
        $error("sha256_nonce_sched: RST_CYC must be >= 1 and FIFO_DEPTH >= 32");
    end

    logic [WORD_W-1:0] r_buf [0:31];
    logic              r_blocks, r_dbl;
    logic [4:0]        r_nidx, r_idx;
    logic [WORD_W-1:0] r_nstart, r_ncount, r_cnt;
    logic [8:0]        r_zbits;
    logic [2:0]        r_state, w_next;
    logic [RC_W-1:0]   r_rcnt;
    logic [WD_W-1:0]   r_wdog;
    logic [HASH_W-1:0] r_hash, r_found_hash;
    logic [WORD_W-1:0] r_found_nonce, r_hashes;
    logic              r_busy, r_done, r_found, r_error, r_eng_rstn, r_eng_start;

    logic [WORD_W-1:0] w_nonce;
    logic [8:0]        w_lz;
    logic              w_busy_st, w_abort, w_wr, w_last_word, w_hit, w_next_busy;

    assign w_nonce     = r_nstart + r_cnt;
    assign w_busy_st   = (r_state == ST_ERST) || (r_state == ST_FILL) ||
                         (r_state == ST_RUN)  || (r_state == ST_CHK);
    assign w_abort     = abort_i && w_busy_st;
    assign w_wr        = (r_state == ST_FILL) && !eng.fifo_full_i && !abort_i;
    assign w_last_word = (r_idx == {r_blocks, 4'hF});
    assign w_hit       = (w_lz >= clamp_zbits(r_zbits));
    assign w_next_busy = (w_next == ST_ERST) || (w_next == ST_FILL) ||
                         (w_next == ST_RUN)  || (w_next == ST_CHK);

    sha256_lzc256 u_lzc (
        .din (r_hash),
        .lz  (w_lz)
    );

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = ST_FIN;
        end else begin
            case (r_state)
                ST_IDLE: if (go_i) w_next = (nonce_count_i == '0) ? ST_FIN : ST_ERST;
                ST_ERST: if (r_rcnt == RC_LAST) w_next = ST_FILL;
                ST_FILL: if (w_wr && w_last_word) w_next = ST_RUN;
                ST_RUN: begin
                    if (eng.eng_valid_i)       w_next = ST_CHK;
                    else if (r_wdog == WD_LAST) w_next = ST_FIN;
                end
                ST_CHK:  w_next = (w_hit || r_cnt == r_ncount - 32'd1) ? ST_FIN : ST_ERST;
                ST_FIN:  w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Message buffer keeps its contents across reset; software reloads it.
    always_ff @(posedge clk_i) begin
        if (msg_we_i && !r_busy) r_buf[msg_addr_i] <= msg_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_error       <= 1'b0;
            r_eng_rstn    <= 1'b0;
            r_eng_start   <= 1'b0;
            r_dbl         <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_hashes      <= '0;
            r_hash        <= '0;
            r_blocks      <= 1'b0;
            r_nidx        <= '0;
            r_nstart      <= '0;
            r_ncount      <= '0;
            r_zbits       <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_rcnt        <= '0;
            r_wdog        <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= w_next_busy;
            r_done      <= (w_next == ST_FIN);
            r_eng_rstn  <= !((w_next == ST_ERST) || (w_next == ST_FIN));
            r_eng_start <= (w_next == ST_RUN);
            r_rcnt      <= (r_state == ST_ERST) ? r_rcnt + 1'b1 : '0;
            r_wdog      <= (r_state == ST_RUN)  ? r_wdog + 1'b1 : '0;
            if (r_state != ST_FILL) r_idx <= '0;
            else if (w_wr)          r_idx <= r_idx + 5'd1;

            case (r_state)
                ST_IDLE: if (go_i) begin
                    r_blocks <= blocks_i;
                    r_nidx   <= nonce_idx_i;
                    r_nstart <= nonce_start_i;
                    r_ncount <= nonce_count_i;
                    r_zbits  <= zbits_i;
                    r_dbl    <= dbl_hash_i;
                    r_found  <= 1'b0;
                    r_error  <= 1'b0;
                    r_hashes <= '0;
                    r_cnt    <= '0;
                end
                ST_RUN: if (!w_abort) begin
                    if (eng.eng_valid_i) begin
                        r_hash   <= eng.eng_hash_i;
                        r_hashes <= r_hashes + 32'd1;
                    end else if (r_wdog == WD_LAST) begin
                        r_error  <= 1'b1;
                    end
                end
                ST_CHK: if (!w_abort) begin
                    if (w_hit) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= w_nonce;
                        r_found_hash  <= r_hash;
                    end else if (r_cnt != r_ncount - 32'd1) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign found_o            = r_found;
    assign error_o            = r_error;
    assign found_nonce_o      = r_found_nonce;
    assign found_hash_o       = r_found_hash;
    assign hashes_done_o      = r_hashes;
    assign eng.eng_rstn_o     = r_eng_rstn;
    assign eng.eng_start_o    = r_eng_start;
    assign eng.eng_dbl_hash_o = r_dbl;
    assign eng.fifo_wr_en_o   = w_wr;
    assign eng.fifo_wr_dat_o  = (r_state != ST_FILL) ? '0 :
                                (r_idx == r_nidx)    ? w_nonce : r_buf[r_idx];
endmodule
`default_nettype wire

// File: tb/tb_sha256_nonce_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sha256_nonce_sched                                                |
// | Mock-engine bench: vector table, directed corners, random sweeps.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sha256_nonce_sched;
    localparam int RST_CYC = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam logic [255:0] H_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_DBL = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

    logic clk = 1'b0, rst = 1'b1;
    logic msg_we = 0, blocks = 0, dbl_hash = 0, go = 0, abort = 0;
    logic [4:0] msg_addr = 0, nonce_idx = 0;
    logic [31:0] msg_dat = 0, nonce_start = 0, nonce_count = 0;
    logic [8:0] zbits = 0;
    logic busy, done, found, error;
    logic [31:0] found_nonce, hashes_done;
    logic [255:0] found_hash;

    sha256_nonce_sched_if u_if ();

    sha256_nonce_sched #(.RST_CYC(RST_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .msg_we_i(msg_we), .msg_addr_i(msg_addr), .msg_dat_i(msg_dat),
        .blocks_i(blocks), .nonce_idx_i(nonce_idx), .nonce_start_i(nonce_start),
        .nonce_count_i(nonce_count), .zbits_i(zbits), .dbl_hash_i(dbl_hash), .go_i(go),
        .abort_i(abort), .busy_o(busy), .done_o(done), .found_o(found), .error_o(error),
        .found_nonce_o(found_nonce), .found_hash_o(found_hash), .hashes_done_o(hashes_done),
        .eng(u_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] bufm [0:31];
    logic [31:0] cap_q [$];

    // ---------------- mock engine ----------------
    int mode = 0, lat = 0, cur_nidx = 0, m_wcnt = 0, m_lat = 0;
    bit full_tog = 0, m_started = 0;
    logic [31:0] key = 0, m_nonce = 0;
    logic [223:0] tail = 0;

    function automatic logic [255:0] mock_hash(input logic [31:0] n, input logic dbl);
        case (mode)
            0: return {n ^ key, tail};
            1: return dbl ? H_DBL : H_ABC;
            3: return {n - 32'd5, 224'd0};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst || !u_if.eng_rstn_o) begin
            m_wcnt <= 0; m_started <= 0; m_nonce <= '0;
            u_if.eng_valid_i <= 1'b0; u_if.eng_hash_i <= '0;
        end else begin
            if (u_if.fifo_wr_en_o) begin
                cap_q.push_back(u_if.fifo_wr_dat_o);
                if (m_wcnt == cur_nidx) m_nonce <= u_if.fifo_wr_dat_o;
                m_wcnt <= m_wcnt + 1;
            end
            if (u_if.eng_start_o && !m_started) begin
                m_started <= 1; m_lat <= lat;
            end else if (m_started && !u_if.eng_valid_i && mode != 2) begin
                if (m_lat == 0) begin
                    u_if.eng_valid_i <= 1'b1;
                    u_if.eng_hash_i  <= mock_hash(m_nonce, u_if.eng_dbl_hash_o);
                end else m_lat <= m_lat - 1;
            end
        end
    end

    always @(posedge clk) u_if.fifo_full_i <= (rst || !full_tog) ? 1'b0 : ~u_if.fifo_full_i;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_buf(input bit abc);
        for (int i = 0; i < 32; i++) begin
            bufm[i] = abc ? ((i == 0) ? 32'h61626380 : (i == 15) ? 32'h18 : 32'h0) : $urandom;
            msg_we = 1; msg_addr = 5'(i); msg_dat = bufm[i];
            tick();
        end
        msg_we = 0;
    endtask

    task automatic start_job(input logic [31:0] st, input logic [31:0] cnt, input logic [8:0] zb,
                             input logic blk, input logic [4:0] nidx, input logic dbl);
        nonce_start = st; nonce_count = cnt; zbits = zb; blocks = blk; nonce_idx = nidx; dbl_hash = dbl;
        cur_nidx = int'(nidx); cap_q.delete();
        go = 1; tick(); go = 0;
        nonce_start = $urandom; nonce_count = $urandom; zbits = 9'($urandom);
        blocks = ~blk; nonce_idx = 5'($urandom); dbl_hash = ~dbl;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20000) begin tick(); n++; end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic verify_stream(input int nw, input int nidx, input logic [31:0] st, input int nn);
        chk("stream_len", 256'(cap_q.size()), 256'(nw * nn));
        for (int i = 0; i < cap_q.size() && i < nw * nn; i++) begin
            int w = i % nw;
            logic [31:0] e = (w == nidx) ? st + 32'(i / nw) : bufm[w];
            chk("stream_word", cap_q[i], e);
        end
    endtask

    function automatic int lzc_ref(input logic [255:0] h);
        int z = 0;
        while (z < 256 && h[255 - z] == 1'b0) z++;
        return z;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] st, cnt; logic [8:0] zb; logic blk; logic [4:0] nidx; logic dbl; int md;
        logic e_found; logic [31:0] e_nonce, e_hd; logic [255:0] e_hash;
    } vec_t;
    vec_t vt [6];

    initial begin
        int n, t0;
        vt[0] = '{32'h12345678, 1, 0, 0, 31, 0, 1, 1, 32'h12345678, 1, H_ABC};
        vt[1] = '{32'h12345678, 1, 0, 0, 31, 1, 1, 1, 32'h12345678, 1, H_DBL};
        vt[2] = '{32'hFFFFFFF0, 32, 28, 0, 3, 0, 3, 1, 32'h5, 22, 256'd0};
        vt[3] = '{32'd3, 4, 300, 1, 20, 0, 3, 1, 32'h5, 3, 256'd0};
        vt[4] = '{32'd100, 3, 256, 1, 0, 0, 3, 0, 32'h0, 3, 256'd0};
        vt[5] = '{32'd7, 0, 0, 1, 2, 0, 0, 0, 32'h0, 0, 256'd0};

        tick(); tick();
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_found", found, 0);       chk("rst_error", error, 0);
        chk("rst_nonce", found_nonce, 0); chk("rst_hash", found_hash, 0);
        chk("rst_hd", hashes_done, 0);    chk("rst_eng_rstn", u_if.eng_rstn_o, 0);
        chk("rst_start", u_if.eng_start_o, 0); chk("rst_dbl", u_if.eng_dbl_hash_o, 0);
        chk("rst_wr_en", u_if.fifo_wr_en_o, 0); chk("rst_wr_dat", u_if.fifo_wr_dat_o, 0);
        rst = 0; tick();
        chk("idle_eng_rstn", u_if.eng_rstn_o, 1);

        load_buf(1);
        for (int v = 0; v < 6; v++) begin
            if (v == 2) load_buf(0);
            mode = vt[v].md; lat = 2;
            start_job(vt[v].st, vt[v].cnt, vt[v].zb, vt[v].blk, vt[v].nidx, vt[v].dbl);
            wait_done(n);
            chk($sformatf("v%0d_found", v), found, vt[v].e_found);
            chk($sformatf("v%0d_error", v), error, 0);
            chk($sformatf("v%0d_hd", v), hashes_done, vt[v].e_hd);
            chk($sformatf("v%0d_busy", v), busy, 0);
            chk($sformatf("v%0d_eng_rstn", v), u_if.eng_rstn_o, 0);
            if (vt[v].e_found) begin
                chk($sformatf("v%0d_nonce", v), found_nonce, vt[v].e_nonce);
                chk($sformatf("v%0d_hash", v), found_hash, vt[v].e_hash);
            end
            if (vt[v].cnt == 0) chk("cnt0_latency_le2", 256'(n <= 2), 1);
            verify_stream(vt[v].blk ? 32 : 16, int'(vt[v].nidx), vt[v].st, int'(vt[v].e_hd));
            tick();
            chk($sformatf("v%0d_done_pulse", v), done, 0);
        end

        // engine never answers: watchdog fires 64 cycles after start rises
        mode = 2;
        start_job(32'd50, 5, 0, 0, 4, 0);
        n = 0;
        while (!u_if.eng_start_o && n < 200) begin tick(); n++; end
        chk("to_start_seen", u_if.eng_start_o, 1);
        t0 = n; wait_done(n);
        chk("to_latency", 256'(n), 256'(TIMEOUT_CYC));
        chk("to_error", error, 1); chk("to_found", found, 0);
        chk("to_hd", hashes_done, 0); chk("to_eng_rstn", u_if.eng_rstn_o, 0);
        verify_stream(16, 4, 32'd50, 1);
        tick(); tick();
        chk("to_error_sticky", error, 1);

        // abort during FILL
        mode = 0; key = 32'h0; tail = '1;
        start_job(32'd9, 4, 0, 1, 6, 0);
        chk("go_clears_error", error, 0);
        n = 0;
        while (!u_if.fifo_wr_en_o && n < 50) begin tick(); n++; end
        chk("ab_fill_seen", u_if.fifo_wr_en_o, 1);
        abort = 1; #1;
        chk("ab_wr_en_drop", u_if.fifo_wr_en_o, 0);
        tick(); abort = 0;
        chk("ab_done", done, 1); chk("ab_busy", busy, 0);
        chk("ab_found", found, 0); chk("ab_error", error, 0); chk("ab_hd", hashes_done, 0);
        tick();

        // FIFO back-pressure on a 2-block fill, buffer write while busy
        full_tog = 1; lat = 1;
        start_job(32'hABCD0000, 1, 0, 1, 7, 0);
        msg_we = 1; msg_addr = 5'd3; msg_dat = ~bufm[3]; tick(); msg_we = 0;
        wait_done(n); full_tog = 0;
        chk("ff_found", found, 1); chk("ff_hd", hashes_done, 1);
        chk("ff_nonce", found_nonce, 32'hABCD0000);
        verify_stream(32, 7, 32'hABCD0000, 1);
        tick();

        // reset in the middle of a job
        start_job(32'd1, 10, 200, 0, 0, 1);
        repeat (10) tick();
        rst = 1; tick(); rst = 0;
        chk("mr_busy", busy, 0); chk("mr_eng_rstn", u_if.eng_rstn_o, 0);
        chk("mr_dbl", u_if.eng_dbl_hash_o, 0); chk("mr_start", u_if.eng_start_o, 0);
        tick();

        // randomized sweeps against a nonce-by-nonce reference
        for (int r = 0; r < 12; r++) begin
            logic [31:0] st, cnt, e_nonce, e_hd; logic [8:0] zb; logic blk, dbl, e_found;
            logic [4:0] nidx; logic [255:0] e_hash, h; int zeff;
            mode = 0; key = $urandom; lat = $urandom_range(0, 10);
            for (int i = 0; i < 7; i++) tail[i*32 +: 32] = $urandom;
            st = (r % 4 == 0) ? 32'hFFFFFFFE : $urandom;
            cnt = $urandom_range(1, 6); zb = 9'($urandom_range(0, 8));
            if (r == 5) zb = 9'd400;
            blk = 1'($urandom); dbl = 1'($urandom);
            nidx = blk ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            zeff = (zb > 256) ? 256 : int'(zb);
            e_found = 0; e_hd = 0; e_nonce = 0; e_hash = 0;
            for (int k = 0; k < int'(cnt) && !e_found; k++) begin
                h = mock_hash(st + 32'(k), dbl);
                e_hd++;
                if (lzc_ref(h) >= zeff) begin e_found = 1; e_nonce = st + 32'(k); e_hash = h; end
            end
            start_job(st, cnt, zb, blk, nidx, dbl);
            wait_done(n);
            chk($sformatf("r%0d_found", r), found, e_found);
            chk($sformatf("r%0d_hd", r), hashes_done, e_hd);
            chk($sformatf("r%0d_error", r), error, 0);
            if (e_found) begin
                chk($sformatf("r%0d_nonce", r), found_nonce, e_nonce);
                chk($sformatf("r%0d_hash", r), found_hash, e_hash);
            end
            verify_stream(blk ? 32 : 16, int'(nidx), st, int'(e_hd));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal;
    end
endmodule
`default_nettype wire
